// File: rtl/fp2int_rr_arbiter.sv
// Round-robin front end sharing one in-order float-to-int unit among NUM_REQ requesters.
// Optional feature: define FP2INT_ARB_PERF_EN to add issue/stall/backpressure counters.
module fp2int_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int TAG_W    = 8,
  parameter int ID_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*3-1:0]     req_op_i,
  input  logic [NUM_REQ*64-1:0]    req_a_i,
  input  logic [NUM_REQ*3-1:0]     req_rm_i,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
  output logic                     unit_in_valid_o,
  input  logic                     unit_in_ready_i,
  output logic [2:0]               unit_op_o,
  output logic [63:0]              unit_a_o,
  output logic [2:0]               unit_rm_o,
  input  logic                     unit_out_valid_i,
  output logic                     unit_out_ready_o,
  input  logic [63:0]              unit_result_i,
  input  logic [4:0]               unit_fflags_i,
  output logic [NUM_REQ-1:0]       resp_valid_o,
  input  logic [NUM_REQ-1:0]       resp_ready_i,
  output logic [63:0]              resp_result_o,
  output logic [4:0]               resp_fflags_o,
  output logic [TAG_W-1:0]         resp_tag_o,
  output logic                     err_o
`ifdef FP2INT_ARB_PERF_EN
  ,
  output logic [31:0]              perf_issue_o,
  output logic [31:0]              perf_stall_o,
  output logic [31:0]              perf_bp_o
`endif
);

  localparam int AW = $clog2(ID_DEPTH);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  fifo_id  [ID_DEPTH];
  logic [TAG_W-1:0] fifo_tag [ID_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             found;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W:0]    cand_sum;
  logic [ID_W-1:0]  cand;
  logic [TAG_W-1:0] grant_tag;
  logic [ID_W-1:0]  head_id;
  logic             push;
  logic             pop;

  assign fifo_full  = (count == (AW+1)'(ID_DEPTH));
  assign fifo_empty = (count == '0);
  assign head_id    = fifo_id[rd_ptr];

  // Scan from the round-robin pointer upward with wrap; first valid requester wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      cand = cand_sum[ID_W-1:0];
      if (!found && req_valid_i[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant_valid = found && !fifo_full;
  end

  always_comb begin
    unit_op_o   = '0;
    unit_a_o    = '0;
    unit_rm_o   = '0;
    grant_tag   = '0;
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_valid && grant_idx == ID_W'(i)) begin
        unit_op_o      = req_op_i[i*3 +: 3];
        unit_a_o       = req_a_i[i*64 +: 64];
        unit_rm_o      = req_rm_i[i*3 +: 3];
        grant_tag      = req_tag_i[i*TAG_W +: TAG_W];
        req_ready_o[i] = unit_in_ready_i;
      end
    end
  end

  assign unit_in_valid_o = grant_valid;
  assign push            = grant_valid && unit_in_ready_i;

  // Results come back in issue order, so the FIFO head always names the owner.
  always_comb begin
    resp_valid_o     = '0;
    unit_out_ready_o = 1'b0;
    resp_result_o    = '0;
    resp_fflags_o    = '0;
    resp_tag_o       = '0;
    if (!fifo_empty) begin
      resp_valid_o[head_id] = unit_out_valid_i;
      unit_out_ready_o      = resp_ready_i[head_id];
      resp_result_o         = unit_result_i;
      resp_fflags_o         = unit_fflags_i;
      resp_tag_o            = fifo_tag[rd_ptr];
    end
  end

  assign pop = !fifo_empty && unit_out_valid_i && unit_out_ready_o;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr]  <= grant_idx;
      fifo_tag[wr_ptr] <= grant_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rr_ptr <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // A result with nothing outstanding means the unit and arbiter lost sync.
      if (fifo_empty && unit_out_valid_i) err_o <= 1'b1;
    end
  end

`ifdef FP2INT_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_o <= '0;
      perf_stall_o <= '0;
      perf_bp_o    <= '0;
    end else begin
      if (push) perf_issue_o <= perf_issue_o + 32'd1;
      if ((|req_valid_i) && !push) perf_stall_o <= perf_stall_o + 32'd1;
      if (unit_out_valid_i && !unit_out_ready_o) perf_bp_o <= perf_bp_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp2int_rr_arbiter.sv
// Randomized bench for fp2int_rr_arbiter with a queue-based reference model and a modelled 2-cycle unit.
module tb_fp2int_rr_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int TAG_W    = 8;
  localparam int ID_DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ*3-1:0]     req_op_i;
  logic [NUM_REQ*64-1:0]    req_a_i;
  logic [NUM_REQ*3-1:0]     req_rm_i;
  logic [NUM_REQ*TAG_W-1:0] req_tag_i;
  logic                     unit_in_valid_o;
  logic                     unit_in_ready_i;
  logic [2:0]               unit_op_o;
  logic [63:0]              unit_a_o;
  logic [2:0]               unit_rm_o;
  logic                     unit_out_valid_i;
  logic                     unit_out_ready_o;
  logic [63:0]              unit_result_i;
  logic [4:0]               unit_fflags_i;
  logic [NUM_REQ-1:0]       resp_valid_o;
  logic [NUM_REQ-1:0]       resp_ready_i;
  logic [63:0]              resp_result_o;
  logic [4:0]               resp_fflags_o;
  logic [TAG_W-1:0]         resp_tag_o;
  logic                     err_o;
`ifdef FP2INT_ARB_PERF_EN
  logic [31:0] perf_issue_o, perf_stall_o, perf_bp_o;
  int perf_issue_m, perf_stall_m, perf_bp_m;
`endif

  fp2int_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TAG_W(TAG_W), .ID_DEPTH(ID_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_rm_i(req_rm_i), .req_tag_i(req_tag_i),
    .unit_in_valid_o(unit_in_valid_o), .unit_in_ready_i(unit_in_ready_i),
    .unit_op_o(unit_op_o), .unit_a_o(unit_a_o), .unit_rm_o(unit_rm_o),
    .unit_out_valid_i(unit_out_valid_i), .unit_out_ready_o(unit_out_ready_o),
    .unit_result_i(unit_result_i), .unit_fflags_i(unit_fflags_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_result_o(resp_result_o), .resp_fflags_o(resp_fflags_o),
    .resp_tag_o(resp_tag_o), .err_o(err_o)
`ifdef FP2INT_ARB_PERF_EN
    , .perf_issue_o(perf_issue_o), .perf_stall_o(perf_stall_o), .perf_bp_o(perf_bp_o)
`endif
  );

  always #5 clk = ~clk;

  // Outstanding requests in issue order, and the modelled unit's result pipeline.
  typedef struct packed { logic [7:0] id; logic [TAG_W-1:0] tag; } id_ent_t;
  typedef struct packed { logic [63:0] res; logic [4:0] ff; logic [31:0] due; } unit_ent_t;
  id_ent_t   id_q[$];
  unit_ent_t unit_q[$];

  int rr_model;
  int cycle_no;
  bit err_model;
  bit force_spurious;
  int n_checks;
  int n_errors;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic driveUnit();
    if (unit_q.size() > 0 && int'(unit_q[0].due) <= cycle_no) begin
      unit_out_valid_i = 1'b1;
      unit_result_i    = unit_q[0].res;
      unit_fflags_i    = unit_q[0].ff;
    end else begin
      unit_out_valid_i = force_spurious;
      unit_result_i    = force_spurious ? 64'hDEAD_BEEF : 64'h0;
      unit_fflags_i    = '0;
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_op_i[i*3 +: 3]          = 3'($urandom);
      req_rm_i[i*3 +: 3]          = 3'($urandom);
      req_a_i[i*64 +: 64]         = {$urandom, $urandom};
      req_tag_i[i*TAG_W +: TAG_W] = TAG_W'($urandom);
    end
    req_valid_i     = NUM_REQ'($urandom);
    unit_in_ready_i = ($urandom % 4) != 0;
    resp_ready_i    = NUM_REQ'($urandom) | NUM_REQ'($urandom);
  endtask

  // One clock: check combinational outputs against the model, then advance the model.
  task automatic runCycle();
    int g;
    int h;
    bit has_head;
    bit exp_out_ready;
    bit issue;
    bit pop;
    logic [63:0] exp_a;
    driveUnit();
    #1;
    g = -1;
    if (id_q.size() < ID_DEPTH)
      for (int k = 0; k < NUM_REQ; k++)
        if (g < 0 && ((req_valid_i >> ((rr_model + k) % NUM_REQ)) & 1) != 0) g = (rr_model + k) % NUM_REQ;
    exp_a = (g >= 0) ? 64'(req_a_i >> (64 * g)) : 64'h0;
    checkOutput("req_ready", req_ready_o, (g >= 0 && unit_in_ready_i) ? 64'(1 << g) : 64'h0);
    checkOutput("in_valid", unit_in_valid_o, 64'(g >= 0));
    checkOutput("unit_op", unit_op_o, (g >= 0) ? 64'(3'(req_op_i >> (3 * g))) : 64'h0);
    checkOutput("unit_a", unit_a_o, exp_a);
    checkOutput("unit_rm", unit_rm_o, (g >= 0) ? 64'(3'(req_rm_i >> (3 * g))) : 64'h0);
    has_head = id_q.size() > 0;
    h = has_head ? int'(id_q[0].id) : 0;
    exp_out_ready = has_head && (((resp_ready_i >> h) & 1) != 0);
    checkOutput("resp_valid", resp_valid_o, (has_head && unit_out_valid_i) ? 64'(1 << h) : 64'h0);
    checkOutput("out_ready", unit_out_ready_o, 64'(exp_out_ready));
    checkOutput("resp_tag", resp_tag_o, has_head ? 64'(id_q[0].tag) : 64'h0);
    checkOutput("resp_result", resp_result_o, has_head ? unit_result_i : 64'h0);
    checkOutput("resp_fflags", resp_fflags_o, has_head ? 64'(unit_fflags_i) : 64'h0);
    checkOutput("err", err_o, 64'(err_model));
`ifdef FP2INT_ARB_PERF_EN
    checkOutput("perf_issue", perf_issue_o, 64'(perf_issue_m));
    checkOutput("perf_stall", perf_stall_o, 64'(perf_stall_m));
    checkOutput("perf_bp", perf_bp_o, 64'(perf_bp_m));
`endif
    issue = (g >= 0) && unit_in_ready_i;
    pop   = has_head && unit_out_valid_i && exp_out_ready;
    @(posedge clk);
    if (rst) begin
      id_q.delete();
      unit_q.delete();
      rr_model  = 0;
      err_model = 1'b0;
`ifdef FP2INT_ARB_PERF_EN
      perf_issue_m = 0; perf_stall_m = 0; perf_bp_m = 0;
`endif
    end else begin
      if (!has_head && unit_out_valid_i) err_model = 1'b1;
`ifdef FP2INT_ARB_PERF_EN
      if (issue) perf_issue_m++;
      if (req_valid_i != 0 && !issue) perf_stall_m++;
      if (unit_out_valid_i && !exp_out_ready) perf_bp_m++;
`endif
      if (pop) begin
        void'(id_q.pop_front());
        void'(unit_q.pop_front());
      end
      if (issue) begin
        id_q.push_back('{id: 8'(g), tag: TAG_W'(req_tag_i >> (TAG_W * g))});
        unit_q.push_back('{res: exp_a ^ 64'h0123_4567_89AB_CDEF, ff: 5'($urandom), due: 32'(cycle_no + 2)});
        rr_model = (g + 1) % NUM_REQ;
      end
    end
    cycle_no++;
    @(negedge clk);
    driveUnit();
  endtask

  task automatic drain();
    req_valid_i  = '0;
    resp_ready_i = '1;
    for (int i = 0; i < 50 && id_q.size() > 0; i++) runCycle();
    if (id_q.size() != 0) checkOutput("drain_timeout", 64'(id_q.size()), 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0; n_errors = 0; cycle_no = 0; rr_model = 0;
    err_model = 1'b0; force_spurious = 1'b0;
`ifdef FP2INT_ARB_PERF_EN
    perf_issue_m = 0; perf_stall_m = 0; perf_bp_m = 0;
`endif
    rst = 1'b1;
    req_valid_i = '0; req_op_i = '0; req_a_i = '0; req_rm_i = '0; req_tag_i = '0;
    unit_in_ready_i = 1'b0; resp_ready_i = '1;
    unit_out_valid_i = 1'b0; unit_result_i = 64'h1234; unit_fflags_i = 5'h3;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_req_ready", req_ready_o, 64'h0);
    checkOutput("rst_resp_valid", resp_valid_o, 64'h0);
    checkOutput("rst_out_ready", unit_out_ready_o, 64'h0);
    checkOutput("rst_resp_result", resp_result_o, 64'h0);
    checkOutput("rst_err", err_o, 64'h0);
    driveUnit();

    // Single request from requester 2, then pointer fairness between 3 and 0.
    req_valid_i = 4'b0100;
    req_a_i[2*64 +: 64] = 64'h3F80_0000;
    req_op_i[2*3 +: 3] = 3'd0;
    req_tag_i[2*TAG_W +: TAG_W] = 8'h5A;
    unit_in_ready_i = 1'b1;
    #1;
    checkOutput("t1_ready", req_ready_o, 64'b0100);
    runCycle();
    req_valid_i = 4'b1001;
    #1;
    checkOutput("fair_first", req_ready_o, 64'b1000);
    runCycle();
    #1;
    checkOutput("fair_second", req_ready_o, 64'b0001);
    checkOutput("t1_resp_valid", resp_valid_o, 64'b0100);
    checkOutput("t1_resp_tag", resp_tag_o, 64'h5A);
    runCycle();
    drain();

    // All requesters valid with full acceptance: grants rotate.
    req_valid_i = '1;
    resp_ready_i = '1;
    unit_in_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) runCycle();
    drain();

    // Hold responses back until the FIFO fills and blocks further grants.
    req_valid_i = '1;
    resp_ready_i = 4'b1101;
    for (int i = 0; i < 6; i++) begin
      if (id_q.size() > 0 && id_q[0].id == 8'd1) resp_ready_i = 4'b0000;
      runCycle();
    end
    #1;
    checkOutput("bp_block", req_ready_o, 64'h0);
    checkOutput("bp_in_valid", unit_in_valid_o, 64'h0);
    checkOutput("bp_out_ready", unit_out_ready_o, 64'h0);
    resp_ready_i = '1;
    drain();

    for (int i = 0; i < 1500; i++) begin
      applyStimulus();
      runCycle();
    end
    drain();

    // Unit result with nothing outstanding sets a sticky error.
    force_spurious = 1'b1;
    runCycle();
    force_spurious = 1'b0;
    driveUnit();
    #1;
    checkOutput("err_rise", err_o, 64'h1);
    for (int i = 0; i < 3; i++) runCycle();

    // Reset with two requests in flight.
    req_valid_i = 4'b0011;
    unit_in_ready_i = 1'b1;
    runCycle();
    runCycle();
    req_valid_i = '0;
    rst = 1'b1;
    runCycle();
    rst = 1'b0;
    req_valid_i = '1;
    #1;
    checkOutput("rst2_err", err_o, 64'h0);
    checkOutput("rst2_resp_valid", resp_valid_o, 64'h0);
    checkOutput("rst2_out_ready", unit_out_ready_o, 64'h0);
    checkOutput("rst2_ptr", req_ready_o, 64'b0001);
`ifdef FP2INT_ARB_PERF_EN
    checkOutput("rst2_perf_issue", perf_issue_o, 64'h0);
    checkOutput("rst2_perf_stall", perf_stall_o, 64'h0);
    checkOutput("rst2_perf_bp", perf_bp_o, 64'h0);
`endif
    for (int i = 0; i < 200; i++) begin
      applyStimulus();
      runCycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
